// File: rtl/acc_multi_dispatcher.sv
// Routes committed accelerator instructions to NumAcc request channels and merges their responses into one writeback port.
// Optional stall-cycle counter enabled by defining ACC_DISPATCH_PERF_EN.
module acc_multi_dispatcher #(
  parameter int NumAcc         = 2,
  parameter int SelLsb         = 25,
  parameter int SelWidth       = 2,
  parameter int ReqDepth       = 2,
  parameter int MaxOutstanding = 4,
  parameter int XLEN           = 64,
  parameter int TransIdWidth   = 3
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             acc_valid_i,
  output logic                             acc_ready_o,
  input  logic [31:0]                      acc_insn_i,
  input  logic [XLEN-1:0]                  acc_rs1_i,
  input  logic [XLEN-1:0]                  acc_rs2_i,
  input  logic [TransIdWidth-1:0]          acc_trans_id_i,
  input  logic                             acc_commit_i,
  input  logic [TransIdWidth-1:0]          acc_commit_trans_id_i,
  output logic                             acc_valid_o,
  output logic [TransIdWidth-1:0]          acc_trans_id_o,
  output logic [XLEN-1:0]                  acc_result_o,
  output logic                             acc_exception_valid_o,
  output logic [NumAcc-1:0]                acc_req_valid_o,
  input  logic [NumAcc-1:0]                acc_req_ready_i,
  output logic [NumAcc*32-1:0]             acc_req_insn_o,
  output logic [NumAcc*XLEN-1:0]           acc_req_rs1_o,
  output logic [NumAcc*XLEN-1:0]           acc_req_rs2_o,
  output logic [NumAcc*TransIdWidth-1:0]   acc_req_trans_id_o,
  input  logic [NumAcc-1:0]                acc_resp_valid_i,
  output logic [NumAcc-1:0]                acc_resp_ready_o,
  input  logic [NumAcc*XLEN-1:0]           acc_resp_result_i,
  input  logic [NumAcc*TransIdWidth-1:0]   acc_resp_trans_id_i,
  input  logic [NumAcc-1:0]                acc_resp_error_i,
  output logic [NumAcc-1:0]                acc_busy_o,
  output logic [31:0]                      perf_stall_cycles_o
);

  localparam int PtrW = $clog2(ReqDepth);
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int RrW  = (NumAcc > 1) ? $clog2(NumAcc) : 1;
  localparam int EntW = 32 + 2 * XLEN + TransIdWidth;
  localparam logic [PtrW:0]   FullLvl = ReqDepth[PtrW:0];
  localparam logic [CntW-1:0] MaxCnt  = MaxOutstanding[CntW-1:0];

  logic [EntW-1:0]         mem_q  [NumAcc][ReqDepth];
  logic [PtrW-1:0]         wptr_q [NumAcc];
  logic [PtrW-1:0]         rptr_q [NumAcc];
  logic [PtrW:0]           fill_q [NumAcc];
  logic [CntW-1:0]         cnt_q  [NumAcc];
  logic [CntW-1:0]         cnt_d  [NumAcc];
  logic [RrW-1:0]          rr_q, rr_d;
  logic                    ill_q, ill_d;
  logic [TransIdWidth-1:0] ill_id_q;
  logic                    wb_valid_q, wb_exc_q;
  logic [TransIdWidth-1:0] wb_id_q;
  logic [XLEN-1:0]         wb_result_q;

  logic                    elig, sel_legal, ill_push, gnt_any;
  logic [SelWidth-1:0]     sel;
  logic [RrW-1:0]          gnt_idx;
  logic [NumAcc-1:0]       empty, full, pop, push, resp_hs, can_push;
  logic [EntW-1:0]         push_ent;

  assign elig      = acc_valid_i && acc_commit_i && (acc_commit_trans_id_i == acc_trans_id_i);
  assign sel       = acc_insn_i[SelLsb +: SelWidth];
  assign sel_legal = (int'(sel) < NumAcc);
  assign push_ent  = {acc_insn_i, acc_rs1_i, acc_rs2_i, acc_trans_id_i};
  assign resp_hs   = acc_resp_valid_i & acc_resp_ready_o;

  // A full FIFO or saturated counter still accepts when it drains in the same cycle.
  for (genvar g = 0; g < NumAcc; g++) begin : g_ch
    logic [EntW-1:0] head;
    assign empty[g]    = (fill_q[g] == '0);
    assign full[g]     = (fill_q[g] == FullLvl);
    assign pop[g]      = !empty[g] && acc_req_ready_i[g];
    assign can_push[g] = (!full[g] || pop[g]) && ((cnt_q[g] < MaxCnt) || resp_hs[g]);
    assign head        = empty[g] ? '0 : mem_q[g][rptr_q[g]];
    assign acc_req_valid_o[g]                                 = !empty[g];
    assign acc_req_insn_o[g*32 +: 32]                         = head[EntW-1 -: 32];
    assign acc_req_rs1_o[g*XLEN +: XLEN]                      = head[2*XLEN+TransIdWidth-1 -: XLEN];
    assign acc_req_rs2_o[g*XLEN +: XLEN]                      = head[XLEN+TransIdWidth-1 -: XLEN];
    assign acc_req_trans_id_o[g*TransIdWidth +: TransIdWidth] = head[TransIdWidth-1:0];
    assign acc_busy_o[g] = (cnt_q[g] != '0) || !empty[g];
  end

  always_comb begin
    acc_ready_o = 1'b0;
    push        = '0;
    ill_push    = 1'b0;
    if (elig && !ill_q) begin
      if (!sel_legal) begin
        acc_ready_o = 1'b1;
        ill_push    = 1'b1;
      end else begin
        for (int i = 0; i < NumAcc; i++) begin
          if ((int'(sel) == i) && can_push[i]) begin
            acc_ready_o = 1'b1;
            push[i]     = 1'b1;
          end
        end
      end
    end
  end

  // Pending illegal-instruction slot always wins; otherwise round-robin from rr_q.
  always_comb begin
    int idx;
    idx              = 0;
    gnt_any          = 1'b0;
    gnt_idx          = '0;
    rr_d             = rr_q;
    acc_resp_ready_o = '0;
    if (!ill_q) begin
      for (int k = 0; k < NumAcc; k++) begin
        idx = (int'(rr_q) + k) % NumAcc;
        if (!gnt_any && acc_resp_valid_i[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = RrW'(idx);
        end
      end
      if (gnt_any) begin
        acc_resp_ready_o[gnt_idx] = 1'b1;
        rr_d = RrW'((int'(gnt_idx) + 1) % NumAcc);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NumAcc; i++) begin
      cnt_d[i] = cnt_q[i];
      if (push[i] && !(resp_hs[i] && (cnt_q[i] != '0))) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (!push[i] && resp_hs[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  assign ill_d = ill_q ? 1'b0 : ill_push;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumAcc; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        fill_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      rr_q        <= '0;
      ill_q       <= 1'b0;
      ill_id_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_exc_q    <= 1'b0;
      wb_id_q     <= '0;
      wb_result_q <= '0;
    end else begin
      for (int i = 0; i < NumAcc; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (push[i]) wptr_q[i] <= wptr_q[i] + 1'b1;
        if (pop[i])  rptr_q[i] <= rptr_q[i] + 1'b1;
        if (push[i] && !pop[i]) begin
          fill_q[i] <= fill_q[i] + 1'b1;
        end else if (!push[i] && pop[i]) begin
          fill_q[i] <= fill_q[i] - 1'b1;
        end
      end
      rr_q  <= rr_d;
      ill_q <= ill_d;
      if (ill_push) ill_id_q <= acc_trans_id_i;
      wb_valid_q <= ill_q || gnt_any;
      wb_exc_q   <= ill_q || (gnt_any && acc_resp_error_i[gnt_idx]);
      if (ill_q) begin
        wb_id_q     <= ill_id_q;
        wb_result_q <= '0;
      end else if (gnt_any) begin
        wb_id_q     <= acc_resp_trans_id_i[gnt_idx*TransIdWidth +: TransIdWidth];
        wb_result_q <= acc_resp_result_i[gnt_idx*XLEN +: XLEN];
      end
    end
  end

  // FIFO payload storage carries no reset; outputs are masked while empty.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumAcc; i++) begin
      if (push[i]) mem_q[i][wptr_q[i]] <= push_ent;
    end
  end

  assign acc_valid_o           = wb_valid_q;
  assign acc_exception_valid_o = wb_exc_q;
  assign acc_trans_id_o        = wb_id_q;
  assign acc_result_o          = wb_result_q;

`ifdef ACC_DISPATCH_PERF_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (elig && !acc_ready_o && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end
  assign perf_stall_cycles_o = stall_q;
`else
  assign perf_stall_cycles_o = '0;
`endif

endmodule
